dsm_word_serializer: RTL and testbench



---
 rtl/dsm_word_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_dsm_word_serializer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dsm_word_serializer.sv
// Serial loader for the DSM fractional word: start/busy/done handshake in, en/sclk/sdata out, MSB first.
// Optional build macro DSM_SER_SWEEP_EN adds an on-chip linear sweep of the word from -2^(WIDTH-2) upward.
module dsm_word_serializer #(
   parameter int WIDTH     = 9,
   parameter int QTR_CYC   = 1,
   parameter int SETUP_CYC = 2,
   parameter int GAP_CYC   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
`ifdef DSM_SER_SWEEP_EN
   input  logic             sweep_go,
   input  logic [7:0]       sweep_step,
   input  logic [15:0]      sweep_hold,
   output logic             sweep_active,
`endif
   output logic             busy,
   output logic             done,
   output logic             en,
   output logic             sclk,
   output logic             sdata
);

   localparam int HI_CYC  = 2 * QTR_CYC;
   localparam int MAX_A   = (SETUP_CYC > HI_CYC) ? SETUP_CYC : HI_CYC;
   localparam int CNT_MAX = ((MAX_A > GAP_CYC) ? MAX_A : GAP_CYC) - 1;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int BIT_W   = (WIDTH < 2) ? 1 : $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, SETUP, LEAD, HIGH, TAIL, GAP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic [WIDTH-1:0]   shreg, shreg_nxt;
   logic               busy_nxt, done_nxt, en_nxt, sclk_nxt, sdata_nxt;
   logic               go;
   logic [WIDTH-1:0]   load_word;

`ifdef DSM_SER_SWEEP_EN
   localparam int SW = WIDTH + 9;
   localparam logic signed [SW-1:0] SW_MIN = SW'(-(2 ** (WIDTH - 2)));
   localparam logic signed [SW-1:0] SW_MAX = SW'((2 ** (WIDTH - 2)) - 1);

   logic signed [SW-1:0] sw_word, sw_next;
   logic                 sw_wait, sw_go;
   logic [15:0]          hold_cnt;

   assign sw_next   = sw_word + signed'(SW'(sweep_step));
   assign sw_go     = sweep_active && sw_wait && (hold_cnt == '0) && (state == IDLE);
   assign go        = sweep_active ? sw_go : start;
   assign load_word = sweep_active ? sw_word[WIDTH-1:0] : data_in;

   // sw_wait marks "word ready, waiting to launch"; done is only consumed once that launch happened
   always_ff @(posedge clk) begin
      if (rst) begin
         sweep_active <= 1'b0;
         sw_wait      <= 1'b0;
         hold_cnt     <= '0;
         sw_word      <= '0;
      end else if (!sweep_active) begin
         if (sweep_go && state == IDLE) begin
            sweep_active <= 1'b1;
            sw_word      <= SW_MIN;
            sw_wait      <= 1'b1;
            hold_cnt     <= '0;
         end
      end else if (sw_go) begin
         sw_wait <= 1'b0;
      end else if (done && !sw_wait) begin
         if (sw_next > SW_MAX) begin
            sweep_active <= 1'b0;
         end else begin
            sw_word  <= sw_next;
            sw_wait  <= 1'b1;
            hold_cnt <= sweep_hold;
         end
      end else if (sw_wait && hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 16'd1;
      end
   end
`else
   assign go        = start;
   assign load_word = data_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         en      <= 1'b0;
         sclk    <= 1'b0;
         sdata   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= shreg_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         en      <= en_nxt;
         sclk    <= sclk_nxt;
         sdata   <= sdata_nxt;
      end
   end

   // outputs are computed for the state being entered so every pin comes straight from a flop
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      en_nxt    = en;
      sclk_nxt  = sclk;
      sdata_nxt = sdata;
      case (state)
         IDLE: begin
            busy_nxt  = 1'b0;
            en_nxt    = 1'b0;
            sclk_nxt  = 1'b0;
            sdata_nxt = 1'b0;
            if (go) begin
               state_nxt = SETUP;
               shreg_nxt = load_word;
               bit_nxt   = BIT_W'(WIDTH - 1);
               cnt_nxt   = CNT_W'(SETUP_CYC - 1);
               busy_nxt  = 1'b1;
               en_nxt    = 1'b1;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nxt = LEAD;
               cnt_nxt   = CNT_W'(QTR_CYC - 1);
               sdata_nxt = shreg[WIDTH-1];
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         LEAD: begin
            if (cnt == '0) begin
               state_nxt = HIGH;
               cnt_nxt   = CNT_W'(HI_CYC - 1);
               sclk_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               state_nxt = TAIL;
               cnt_nxt   = CNT_W'(QTR_CYC - 1);
               sclk_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         TAIL: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (bit_cnt != '0) begin
               state_nxt = LEAD;
               cnt_nxt   = CNT_W'(QTR_CYC - 1);
               shreg_nxt = shreg << 1;
               bit_nxt   = bit_cnt - 1'b1;
               sdata_nxt = shreg[WIDTH-2];
            end else begin
               state_nxt = GAP;
               cnt_nxt   = CNT_W'(GAP_CYC - 1);
               en_nxt    = 1'b0;
               sdata_nxt = 1'b0;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            en_nxt    = 1'b0;
            sclk_nxt  = 1'b0;
            sdata_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dsm_word_serializer.sv
// Randomized bench for dsm_word_serializer: per-cycle pin waveform checked against a frame-timing model.
module tb_dsm_word_serializer;
   localparam int W = 9;
   localparam int Q = 1;
   localparam int S = 2;
   localparam int G = 8;
   localparam int T = S + W * 4 * Q + G;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         busy, done, en, sclk, sdata;
   int           n_chk = 0;
   int           n_err = 0;

   dsm_word_serializer #(.WIDTH(W), .QTR_CYC(Q), .SETUP_CYC(S), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start),
      .busy(busy), .done(done), .en(en), .sclk(sclk), .sdata(sdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {busy,done,en,sclk,sdata} after edge m counted from the accept edge (m=0)
   function automatic logic [4:0] exp_at(input logic [W-1:0] w, input int m);
      int j, b, ph;
      if (m < S) return 5'b10100;
      if (m < S + W * 4 * Q) begin
         j  = m - S;
         b  = j / (4 * Q);
         ph = j % (4 * Q);
         return {1'b1, 1'b0, 1'b1, (ph >= Q && ph < 3 * Q), w[W-1-b]};
      end
      if (m < T) return 5'b10000;
      if (m == T) return 5'b01000;
      return 5'b00000;
   endfunction

   // caller has already driven start=1 / data_in=w before the accept edge
   task automatic frame(input logic [W-1:0] w, input bit noisy, input int rst_at,
                        input bit chain, input logic [W-1:0] nxt);
      logic [W-1:0] cap;
      int           ncap;
      logic         sclk_d;
      cap = '0; ncap = 0; sclk_d = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int m = 0; m <= T + 1; m++) begin
         if (rst_at >= 0 && m == rst_at + 1) begin
            chk("rst_abort", 32'({busy, done, en, sclk, sdata}), 32'(0));
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               chk("rst_nodone", 32'({busy, done, en}), 32'(0));
            end
            return;
         end
         chk("pins", 32'({busy, done, en, sclk, sdata}), 32'(exp_at(w, m)));
         if (sclk && !sclk_d) begin
            cap = {cap[W-2:0], sdata};
            ncap++;
         end
         sclk_d = sclk;
         if (rst_at >= 0 && m == rst_at) rst = 1'b1;
         if (noisy && m < T) begin
            data_in = W'($urandom);
            start   = ($urandom_range(0, 3) == 0);
         end else if (m >= T) begin
            start = 1'b0;
         end
         if (m == T) begin
            chk("capture", 32'(cap), 32'(w));
            chk("nbits", 32'(ncap), 32'(W));
            if (chain) begin
               data_in = nxt;
               start   = 1'b1;
               return;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input logic [W-1:0] w, input bit noisy);
      @(negedge clk);
      data_in = w;
      start   = 1'b1;
      frame(w, noisy, -1, 1'b0, '0);
   endtask

   initial begin
      logic [W-1:0] fixed [6];
      logic [W-1:0] a, b;
      fixed[0] = 9'h0FF; fixed[1] = 9'h180; fixed[2] = 9'h07F;
      fixed[3] = 9'h100; fixed[4] = 9'h000; fixed[5] = 9'h1FF;

      repeat (3) @(posedge clk);
      #1;
      chk("reset", 32'({busy, done, en, sclk, sdata}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle", 32'({busy, done, en, sclk, sdata}), 32'(0));

      foreach (fixed[i]) send(fixed[i], 1'b0);

      // starts and data changes while busy must not disturb the frame
      send(9'h0A5, 1'b1);
      send(9'h15A, 1'b1);

      // start in the done cycle chains straight into the next frame
      @(negedge clk);
      data_in = 9'h133; start = 1'b1;
      frame(9'h133, 1'b0, -1, 1'b1, 9'h0CC);
      frame(9'h0CC, 1'b0, -1, 1'b0, '0);

      // reset mid-transfer, then a clean frame
      @(negedge clk);
      data_in = 9'h1E7; start = 1'b1;
      frame(9'h1E7, 1'b0, 15, 1'b0, '0);
      send(9'h06D, 1'b0);

      for (int r = 0; r < 20; r++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 3))
            0: begin
               @(negedge clk); data_in = a; start = 1'b1;
               frame(a, 1'b1, -1, 1'b1, b);
               frame(b, 1'b0, -1, 1'b0, '0);
            end
            1: begin
               @(negedge clk); data_in = a; start = 1'b1;
               frame(a, 1'b0, int'($urandom_range(1, T - 2)), 1'b0, '0);
               send(b, 1'b0);
            end
            default: send(a, $urandom_range(0, 1) == 1);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
